// File: rtl/assoc_buf_ctrl.sv
// Command sequencer for the associative buffer: issues CLR/LOAD/INCR codes to the key and occupancy registers.
// Optional macro DUPLICATE_CHECK_EN: INSERT first looks up the key and reports a duplicate instead of loading.
module assoc_buf_ctrl #(
    parameter int ENTRIES    = 4,
    parameter int IDX_WIDTH  = 2,
    parameter int CTRL_WIDTH = 2
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          req_valid,
    output logic                          req_ready,
    input  logic [1:0]                    req_op,
    input  logic [ENTRIES-1:0]            match_vec,
    output logic [ENTRIES*CTRL_WIDTH-1:0] entry_ctrl,
    output logic [CTRL_WIDTH-1:0]         cnt_ctrl,
    output logic [IDX_WIDTH:0]            occupancy,
    output logic                          full,
    output logic                          empty,
    output logic                          resp_valid,
    output logic                          resp_hit,
    output logic                          resp_evict,
    output logic [IDX_WIDTH-1:0]          resp_idx
);

    localparam logic [1:0] OP_INSERT = 2'd1;
    localparam logic [1:0] OP_LOOKUP = 2'd2;
    localparam logic [1:0] OP_CLEAR  = 2'd3;

    localparam logic [CTRL_WIDTH-1:0] C_NONE = CTRL_WIDTH'(0);
    localparam logic [CTRL_WIDTH-1:0] C_CLR  = CTRL_WIDTH'(1);
    localparam logic [CTRL_WIDTH-1:0] C_LOAD = CTRL_WIDTH'(2);
    localparam logic [CTRL_WIDTH-1:0] C_INCR = CTRL_WIDTH'(3);

    localparam logic [IDX_WIDTH:0] FULL_CNT = (IDX_WIDTH+1)'(ENTRIES);

    typedef enum logic [2:0] {
        S_IDLE, S_INS, S_LK_WAIT, S_LK_EVAL, S_CLR, S_RESP
    } state_t;

    state_t                          state_q;
    logic [ENTRIES-1:0]              valid_q;
    logic [IDX_WIDTH:0]              occ_q;
    logic [IDX_WIDTH-1:0]            ptr_q;
    logic [IDX_WIDTH-1:0]            slot_q;
    logic                            evict_q;
    logic [ENTRIES*CTRL_WIDTH-1:0]   entry_ctrl_q;
    logic [CTRL_WIDTH-1:0]           cnt_ctrl_q;
    logic                            resp_valid_q;
    logic                            resp_hit_q;
    logic                            resp_evict_q;
    logic [IDX_WIDTH-1:0]            resp_idx_q;

    logic [ENTRIES-1:0]              hit_vec;
    logic [IDX_WIDTH-1:0]            free_idx;
    logic                            match_found;
    logic [IDX_WIDTH-1:0]            match_idx;
    logic [IDX_WIDTH-1:0]            slot_d;
    logic                            evict_d;
    logic [ENTRIES*CTRL_WIDTH-1:0]   load_ctrl_d;
    logic                            go_ins;

`ifdef DUPLICATE_CHECK_EN
    logic [1:0] op_q;
    assign go_ins = (op_q == OP_INSERT) && !match_found;
`else
    assign go_ins = 1'b0;
`endif

    assign full       = (occ_q == FULL_CNT);
    assign empty      = (occ_q == '0);
    assign occupancy  = occ_q;
    assign req_ready  = (state_q == S_IDLE);
    assign entry_ctrl = entry_ctrl_q;
    assign cnt_ctrl   = cnt_ctrl_q;
    assign resp_valid = resp_valid_q;
    assign resp_hit   = resp_hit_q;
    assign resp_evict = resp_evict_q;
    assign resp_idx   = resp_idx_q;

    // NOTE: every combinational output gets a default before the loops, so no latch can be inferred.
    always_comb begin
        hit_vec     = match_vec & valid_q;
        free_idx    = '0;
        match_found = 1'b0;
        match_idx   = '0;
        // Scan high-to-low so the last write leaves the lowest qualifying index.
        for (int i = ENTRIES - 1; i >= 0; i--) begin
            if (!valid_q[i]) free_idx = IDX_WIDTH'(i);
            if (hit_vec[i]) begin
                match_found = 1'b1;
                match_idx   = IDX_WIDTH'(i);
            end
        end
        evict_d     = full;
        slot_d      = full ? ptr_q : free_idx;
        load_ctrl_d = '0;
        for (int i = 0; i < ENTRIES; i++) begin
            if (slot_d == IDX_WIDTH'(i)) load_ctrl_d[i*CTRL_WIDTH +: CTRL_WIDTH] = C_LOAD;
        end
    end

    // NOTE: asynchronous active-low reset; all state updates use non-blocking assignments.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= S_IDLE;
            valid_q      <= '0;
            occ_q        <= '0;
            ptr_q        <= '0;
            slot_q       <= '0;
            evict_q      <= 1'b0;
            entry_ctrl_q <= '0;
            cnt_ctrl_q   <= C_NONE;
            resp_valid_q <= 1'b0;
            resp_hit_q   <= 1'b0;
            resp_evict_q <= 1'b0;
            resp_idx_q   <= '0;
`ifdef DUPLICATE_CHECK_EN
            op_q         <= '0;
`endif
        end else begin
            // Ctrl codes and the strobe are one-cycle pulses unless re-armed below.
            resp_valid_q <= 1'b0;
            entry_ctrl_q <= '0;
            cnt_ctrl_q   <= C_NONE;
            case (state_q)
                S_IDLE: begin
                    if (req_valid) begin
`ifdef DUPLICATE_CHECK_EN
                        op_q <= req_op;
`endif
                        case (req_op)
                            OP_INSERT: begin
`ifdef DUPLICATE_CHECK_EN
                                state_q <= S_LK_WAIT;
`else
                                state_q      <= S_INS;
                                slot_q       <= slot_d;
                                evict_q      <= evict_d;
                                entry_ctrl_q <= load_ctrl_d;
                                cnt_ctrl_q   <= evict_d ? C_NONE : C_INCR;
`endif
                            end
                            OP_LOOKUP: state_q <= S_LK_WAIT;
                            OP_CLEAR: begin
                                state_q      <= S_CLR;
                                entry_ctrl_q <= {ENTRIES{C_CLR}};
                                cnt_ctrl_q   <= C_CLR;
                            end
                            default: ;
                        endcase
                    end
                end
                S_LK_WAIT: state_q <= S_LK_EVAL;
                S_LK_EVAL: begin
                    if (go_ins) begin
                        state_q      <= S_INS;
                        slot_q       <= slot_d;
                        evict_q      <= evict_d;
                        entry_ctrl_q <= load_ctrl_d;
                        cnt_ctrl_q   <= evict_d ? C_NONE : C_INCR;
                    end else begin
                        state_q      <= S_RESP;
                        resp_valid_q <= 1'b1;
                        resp_hit_q   <= match_found;
                        resp_evict_q <= 1'b0;
                        resp_idx_q   <= match_idx;
                    end
                end
                S_INS: begin
                    valid_q[slot_q] <= 1'b1;
                    if (evict_q) ptr_q <= ptr_q + IDX_WIDTH'(1);
                    else         occ_q <= occ_q + (IDX_WIDTH+1)'(1);
                    state_q      <= S_RESP;
                    resp_valid_q <= 1'b1;
                    resp_hit_q   <= 1'b0;
                    resp_evict_q <= evict_q;
                    resp_idx_q   <= slot_q;
                end
                S_CLR: begin
                    valid_q      <= '0;
                    occ_q        <= '0;
                    ptr_q        <= '0;
                    state_q      <= S_RESP;
                    resp_valid_q <= 1'b1;
                    resp_hit_q   <= 1'b0;
                    resp_evict_q <= 1'b0;
                    resp_idx_q   <= '0;
                end
                S_RESP:  state_q <= S_IDLE;
                default: state_q <= S_IDLE;
            endcase
        end
    end

endmodule
